// File: rtl/prj_processor_pio_pkg.sv
// Shared definitions for the switch/key input PIO: Avalon word offsets of the
// register map and a constant clog2 used to size the debounce counters.
package prj_processor_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    // Ceiling log2, usable in constant expressions. clog2(1) returns 0.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prj_processor_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser followed, when
// SWITCH_PIO_DEBOUNCE_EN is defined, by a stability counter. The debounced
// value only changes after DEBOUNCE_CYCLES consecutive sync samples that
// disagree with it. Without the macro the bit follows the synchroniser output.
module prj_processor_debounce_bit
    import prj_processor_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef SWITCH_PIO_DEBOUNCE_EN
    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    // Count consecutive disagreeing samples; accept the new level on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stable = stable_q;
`else
    // No debounce: the bit follows the synchroniser output. DEBOUNCE_CYCLES
    // only picks the scope name here and has no functional effect.
    if (DEBOUNCE_CYCLES >= 2) begin : g_direct
        assign stable = sync;
    end else begin : g_direct_short
        assign stable = sync;
    end
`endif

endmodule

// File: rtl/prj_processor_switch_pio.sv
// Avalon-MM input PIO for board switches and keys. Each bit is synchronised
// and (with SWITCH_PIO_DEBOUNCE_EN defined) debounced; any change of a
// debounced bit is latched in edgecapture, and irq is the registered OR of
// edgecapture & irqmask. Build option: SWITCH_PIO_DEBOUNCE_EN.
module prj_processor_switch_pio
    import prj_processor_pio_pkg::*;
#(
    parameter int WIDTH           = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Bus protocol: fixed-latency slave with no wait states. A write is
    // accepted on any clock edge where chipselect=1 and write_n=0. Reads are
    // not gated by chipselect: readdata is reloaded from the address every
    // clock, so it is valid on the cycle after the address is presented.

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        prj_processor_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .din    (in_port[i]),
            .stable (stable[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign edge_det     = stable ^ stable_d;
    assign edge_clr     = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // Delayed copy of the debounced inputs for any-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    // Interrupt mask register, written from the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, a new edge in the same cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~edge_clr) | edge_det;
        end
    end

    // Read mux; unused upper bits and the reserved word read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_RSVD:    rd_mux            = '0;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGE:    rd_mux[WIDTH-1:0] = edgecapture;
        endcase
    end

    // Registered read data and level interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_prj_processor_switch_pio.sv
// Directed bench for prj_processor_switch_pio with WIDTH=9, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Timing expectations follow the build: with
// SWITCH_PIO_DEBOUNCE_EN the input-to-stable latency is 2+4 edges, else 2.
module tb_prj_processor_switch_pio;
    import prj_processor_pio_pkg::*;

    localparam int WIDTH       = 9;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES  = 4;
`ifdef SWITCH_PIO_DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + DEB_CYCLES;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int          checks;
    int          failures;
    logic [31:0] rd;
    logic [31:0] exp_stable;
    int          rise_bit;

    prj_processor_switch_pio #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drivers: called at a negedge, return at the following negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic settle();
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        exp_stable = '0;

        // Reset asserted mid-cycle with all switches high
        #3 reset = 1'b1;
        in_port = 9'h1FF;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        address = ADDR_EDGE;
        @(negedge clk);
        check("rst_edge", readdata, 32'h0);
        address = ADDR_DATA;
        reset   = 1'b0;
        repeat (LAT) @(negedge clk);
        check("rst_data_early", readdata, 32'h0);
        @(negedge clk);
        check("rst_data_lat", readdata, 32'h1FF);
        address = ADDR_EDGE;
        @(negedge clk);
        check("rst_edge_set", readdata, 32'h1FF);
        check("rst_irq_masked", {31'b0, irq}, 32'h0);

        // Return all inputs low and clear captured edges
        in_port = '0;
        settle();
        bus_write(ADDR_EDGE, 32'h1FF);
        bus_read(ADDR_EDGE, rd);
        check("init_clear", rd, 32'h0);

`ifdef SWITCH_PIO_DEBOUNCE_EN
        // Three-cycle glitch must not reach the debounced value
        in_port[0] = 1'b1;
        repeat (3) @(negedge clk);
        in_port[0] = 1'b0;
        settle();
        bus_read(ADDR_DATA, rd);
        check("glitch_data", rd, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("glitch_edge", rd, 32'h0);
        rise_bit = 0;
`else
        // Single-cycle glitch passes straight through and is captured
        in_port[8] = 1'b1;
        @(negedge clk);
        in_port[8] = 1'b0;
        settle();
        bus_read(ADDR_DATA, rd);
        check("glitch_data", rd, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("glitch_edge", rd, 32'h100);
        bus_write(ADDR_EDGE, 32'h100);
        rise_bit = 8;
`endif

        // Held rise: data changes exactly LAT edges after the input
        address            = ADDR_DATA;
        in_port[rise_bit]  = 1'b1;
        exp_stable         = 32'(1) << rise_bit;
        repeat (LAT) @(negedge clk);
        check("rise_early", readdata, 32'h0);
        @(negedge clk);
        check("rise_lat", readdata, exp_stable);
        address = ADDR_EDGE;
        @(negedge clk);
        check("rise_edge", readdata, exp_stable);
        bus_write(ADDR_EDGE, 32'h1FF);

        // Masked interrupt on bit 2
        bus_write(ADDR_IRQMASK, 32'h004);
        bus_read(ADDR_IRQMASK, rd);
        check("mask_rb", rd, 32'h004);
        address    = ADDR_EDGE;
        in_port[2] = 1'b1;
        exp_stable = exp_stable | 32'h4;
        repeat (LAT + 1) @(negedge clk);
        check("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'h1);
        check("irq_edge", readdata, 32'h4);
        bus_write(ADDR_EDGE, 32'h4);
        check("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_clear", {31'b0, irq}, 32'h0);

        // Edge on an unmasked bit must not raise irq
        in_port[3] = 1'b1;
        exp_stable = exp_stable | 32'h8;
        settle();
        check("irq_unmasked", {31'b0, irq}, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("edge3", rd, 32'h8);
        bus_write(ADDR_EDGE, 32'h8);

        // Clear lands on the same edge that captures bit 5: set wins
        in_port[5] = 1'b1;
        exp_stable = exp_stable | 32'h20;
        repeat (LAT) @(negedge clk);
        bus_write(ADDR_EDGE, 32'h20);
        bus_read(ADDR_EDGE, rd);
        check("collide_set_wins", rd, 32'h20);
        bus_write(ADDR_EDGE, 32'h20);
        bus_read(ADDR_EDGE, rd);
        check("w1c_clear", rd, 32'h0);

        // Register map
        bus_read(ADDR_RSVD, rd);
        check("rsvd_read", rd, 32'h0);
        bus_read(ADDR_DATA, rd);
        check("data_read", rd, exp_stable);
        bus_write(ADDR_DATA, 32'hFFFFFFFF);
        bus_read(ADDR_DATA, rd);
        check("data_ro", rd, exp_stable);
        bus_write(ADDR_RSVD, 32'hFFFFFFFF);
        bus_read(ADDR_RSVD, rd);
        check("rsvd_ro", rd, 32'h0);
        bus_write(ADDR_IRQMASK, 32'hFFFFFFFF);
        bus_read(ADDR_IRQMASK, rd);
        check("mask_width", rd, 32'h1FF);
        check("irq_idle", {31'b0, irq}, 32'h0);

        // Full mask: edge on bit 7 raises irq
        in_port[7] = 1'b1;
        exp_stable = exp_stable | 32'h80;
        settle();
        check("irq_bit7", {31'b0, irq}, 32'h1);

        // Reset in the middle of a debounce window, then restart
        address    = ADDR_DATA;
        in_port[1] = 1'b1;
        exp_stable = exp_stable | 32'h2;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT) @(negedge clk);
        check("midrst_early", readdata, 32'h0);
        @(negedge clk);
        check("midrst_lat", readdata, exp_stable);
        bus_read(ADDR_IRQMASK, rd);
        check("midrst_mask", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
